// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: opcodes, funct codes,
// ALU selects, FSM states and the per-state control word.
package multicycle_controller_pkg;

   localparam int OPW_C = 6;
   localparam int FNW_C = 6;
   localparam int SW_C  = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [SW_C-1:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:   begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
         S_DECODE:  c.alu_src_b = 2'b11;
         S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:   c.iord = 1'b1;
         S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
         S_EXECUTE: c.alu_src_a = 1'b1;
         S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         S_BRANCH:  begin c.alu_src_a = 1'b1; c.branch = 1'b1; c.pc_src = 2'b01; end
         S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_ADDIWB:  c.reg_write = 1'b1;
         S_JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [1:0] state_alu_op(input state_t s);
      case (s)
         S_EXECUTE: return ALUOP_FUNCT;
         S_BRANCH:  return ALUOP_SUB;
         default:   return ALUOP_ADD;
      endcase
   endfunction

   function automatic logic rtype_funct_ok(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR) || (f == FN_SLT);
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALUOp class plus the R-type funct field onto the 3-bit AluCon.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_con
);

   // ALU select decode
   always_comb begin
      alu_con = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_con = ALU_ADD;
         ALUOP_SUB: alu_con = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_con = ALU_ADD;
               FN_SUB:  alu_con = ALU_SUB;
               FN_AND:  alu_con = ALU_AND;
               FN_OR:   alu_con = ALU_OR;
               FN_SLT:  alu_con = ALU_SLT;
               default: alu_con = ALU_ADD;
            endcase
         end
         default: alu_con = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle processor control FSM. Control outputs are registered from the
// next state so each one is a clean function of the current state register.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int OPW = OPW_C,
   parameter int FNW = FNW_C,
   parameter int SW  = SW_C
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [OPW-1:0] Op,
   input  logic [FNW-1:0] Funct,
   input  logic           Zero,
   output logic           IorD,
   output logic           MemWrite,
   output logic           IRWrite,
   output logic           PCEn,
   output logic [1:0]     PCSrc,
   output logic           ALUSrcA,
   output logic [1:0]     ALUSrcB,
   output logic [2:0]     AluCon,
   output logic           RegDst,
   output logic           MemtoReg,
   output logic           RegWrite,
   output logic           Illegal,
   output logic [SW-1:0]  State
);

   state_t     state_r;
   state_t     next_state_s;
   ctrl_t      ctrl_r;
   ctrl_t      next_ctrl_s;
   logic [2:0] alu_con_r;
   logic [2:0] next_alu_con_s;
   logic       store_r;
   logic       illegal_s;

   // Next-state decode; Op/Funct are only looked at while in DECODE
   always_comb begin
      next_state_s = S_FETCH;
      illegal_s    = 1'b0;
      case (state_r)
         S_IDLE:  next_state_s = S_FETCH;
         S_FETCH: next_state_s = S_DECODE;
         S_DECODE: begin
            if ((Op == OP_LW) || (Op == OP_SW)) begin
               next_state_s = S_MEMADR;
            end else if ((Op == OP_RTYPE) && rtype_funct_ok(Funct)) begin
               next_state_s = S_EXECUTE;
            end else if (Op == OP_BEQ) begin
               next_state_s = S_BRANCH;
            end else if (Op == OP_ADDI) begin
               next_state_s = S_ADDIEX;
            end else if (Op == OP_J) begin
               next_state_s = S_JUMP;
            end else begin
               next_state_s = S_FETCH;
               illegal_s    = 1'b1;
            end
         end
         S_MEMADR: begin
            if (store_r) begin
               next_state_s = S_MEMWR;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMRD:   next_state_s = S_MEMWB;
         S_EXECUTE: next_state_s = S_ALUWB;
         S_ADDIEX:  next_state_s = S_ADDIWB;
         default:   next_state_s = S_FETCH;
      endcase
   end

   assign next_ctrl_s = state_ctrl(next_state_s);

   // Funct is read while in DECODE, which is when EXECUTE's select gets registered
   alu_decoder u_alu_decoder (
      .alu_op  (state_alu_op(next_state_s)),
      .funct   (Funct),
      .alu_con (next_alu_con_s)
   );

   // State register with its registered control word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= S_IDLE;
         ctrl_r    <= '0;
         alu_con_r <= ALU_ADD;
         store_r   <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         ctrl_r    <= next_ctrl_s;
         alu_con_r <= next_alu_con_s;
         if (state_r == S_DECODE) begin
            store_r <= (Op == OP_SW);
         end else begin
            store_r <= store_r;
         end
      end
   end

   assign IorD     = ctrl_r.iord;
   assign MemWrite = ctrl_r.mem_write;
   assign IRWrite  = ctrl_r.ir_write;
   assign PCSrc    = ctrl_r.pc_src;
   assign ALUSrcA  = ctrl_r.alu_src_a;
   assign ALUSrcB  = ctrl_r.alu_src_b;
   assign AluCon   = alu_con_r;
   assign RegDst   = ctrl_r.reg_dst;
   assign MemtoReg = ctrl_r.mem_to_reg;
   assign RegWrite = ctrl_r.reg_write;
   // Zero is only meaningful in BRANCH, so it bypasses the output register
   assign PCEn     = ctrl_r.pc_write | (ctrl_r.branch & Zero);
   // The opcode is not in the IR before DECODE, so this flag cannot be pre-registered
   assign Illegal  = illegal_s;
   assign State    = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: one task per scenario.
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       IorD, MemWrite, IRWrite, PCEn;
   logic [1:0] PCSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] AluCon;
   logic       RegDst, MemtoReg, RegWrite, Illegal;
   logic [3:0] State;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
      .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluCon(AluCon),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .Illegal(Illegal), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (State !== 4'(S_IDLE)) begin n_bad++; $display("FAIL reset_state got %0d want %0d", State, S_IDLE); end
      n_cmp++;
      if ({IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, RegDst, MemtoReg, RegWrite} !== 12'd0) begin
         n_bad++; $display("FAIL reset_enables got %b want all zero",
            {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, RegDst, MemtoReg, RegWrite});
      end
      n_cmp++;
      if (AluCon !== 3'b010) begin n_bad++; $display("FAIL reset_alucon got %b want 010", AluCon); end
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if (State !== 4'(S_FETCH)) begin n_bad++; $display("FAIL fetch_state got %0d want %0d", State, S_FETCH); end
      n_cmp++;
      if ({IRWrite, PCEn, AluCon, ALUSrcB, ALUSrcA, IorD} !== 9'b1_1_010_01_0_0) begin
         n_bad++; $display("FAIL fetch_ctrl got %b want 110100100", {IRWrite, PCEn, AluCon, ALUSrcB, ALUSrcA, IorD});
      end
   endtask

   task automatic test_lw;
      logic [3:0] exp_st [5];
      exp_st = '{4'(S_DECODE), 4'(S_MEMADR), 4'(S_MEMRD), 4'(S_MEMWB), 4'(S_FETCH)};
      Op = OP_LW;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (State !== exp_st[i]) begin n_bad++; $display("FAIL lw_state%0d got %0d want %0d", i, State, exp_st[i]); end
         n_cmp++;
         if ({MemtoReg, RegWrite} !== {2{i == 3}}) begin
            n_bad++; $display("FAIL lw_wb%0d got %b want %b", i, {MemtoReg, RegWrite}, {2{i == 3}});
         end
         n_cmp++;
         if (IorD !== (i == 2)) begin n_bad++; $display("FAIL lw_iord%0d got %b want %b", i, IorD, (i == 2)); end
      end
   endtask

   task automatic test_rtype;
      logic [5:0] fn_tab [5];
      logic [2:0] ac_tab [5];
      fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ac_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      for (int k = 0; k < 5; k++) begin
         Op = 6'b000000; Funct = fn_tab[k];
         tick();
         tick();
         n_cmp++;
         if ({State, AluCon, ALUSrcA, ALUSrcB} !== {4'(S_EXECUTE), ac_tab[k], 1'b1, 2'b00}) begin
            n_bad++; $display("FAIL rtype_exec%0d got st=%0d alucon=%b want st=%0d alucon=%b", k, State, AluCon, S_EXECUTE, ac_tab[k]);
         end
         tick();
         n_cmp++;
         if ({State, RegDst, MemtoReg, RegWrite} !== {4'(S_ALUWB), 3'b101}) begin
            n_bad++; $display("FAIL rtype_wb%0d got st=%0d rd/m2r/rw=%b want st=%0d 101", k, State, {RegDst, MemtoReg, RegWrite}, S_ALUWB);
         end
         tick();
         n_cmp++;
         if (State !== 4'(S_FETCH)) begin n_bad++; $display("FAIL rtype_ret%0d got %0d want %0d", k, State, S_FETCH); end
      end
   endtask

   task automatic test_branch;
      for (int z = 1; z >= 0; z--) begin
         Op = OP_BEQ; Zero = z[0];
         tick();
         tick();
         n_cmp++;
         if ({State, PCEn, PCSrc, AluCon} !== {4'(S_BRANCH), z[0], 2'b01, 3'b110}) begin
            n_bad++; $display("FAIL beq_z%0d got st=%0d pcen=%b pcsrc=%b alucon=%b want st=%0d pcen=%b 01 110",
               z, State, PCEn, PCSrc, AluCon, S_BRANCH, z[0]);
         end
         Zero = ~z[0];
         #1;
         n_cmp++;
         if (PCEn !== ~z[0]) begin n_bad++; $display("FAIL beq_pcen_comb%0d got %b want %b", z, PCEn, ~z[0]); end
         Zero = z[0];
         tick();
         n_cmp++;
         if (State !== 4'(S_FETCH)) begin n_bad++; $display("FAIL beq_ret%0d got %0d want %0d", z, State, S_FETCH); end
      end
      Zero = 1'b0;
   endtask

   task automatic test_addi_jump;
      Op = OP_ADDI;
      tick();
      tick();
      n_cmp++;
      if ({State, AluCon, ALUSrcA, ALUSrcB} !== {4'(S_ADDIEX), 3'b010, 1'b1, 2'b10}) begin
         n_bad++; $display("FAIL addi_ex got st=%0d alucon=%b srcb=%b", State, AluCon, ALUSrcB);
      end
      tick();
      n_cmp++;
      if ({State, RegDst, MemtoReg, RegWrite} !== {4'(S_ADDIWB), 3'b001}) begin
         n_bad++; $display("FAIL addi_wb got st=%0d rd/m2r/rw=%b want st=%0d 001", State, {RegDst, MemtoReg, RegWrite}, S_ADDIWB);
      end
      tick();
      Op = OP_J;
      tick();
      tick();
      n_cmp++;
      if ({State, PCSrc, PCEn} !== {4'(S_JUMP), 2'b10, 1'b1}) begin
         n_bad++; $display("FAIL jump got st=%0d pcsrc=%b pcen=%b want st=%0d 10 1", State, PCSrc, PCEn, S_JUMP);
      end
      tick();
      n_cmp++;
      if (State !== 4'(S_FETCH)) begin n_bad++; $display("FAIL jump_ret got %0d want %0d", State, S_FETCH); end
   endtask

   task automatic test_illegal;
      logic [11:0] bad_tab [2];
      bad_tab = '{{6'b111111, 6'b000000}, {6'b000000, 6'b000011}};
      for (int k = 0; k < 2; k++) begin
         {Op, Funct} = bad_tab[k];
         tick();
         n_cmp++;
         if ({State, Illegal, RegWrite, MemWrite} !== {4'(S_DECODE), 3'b100}) begin
            n_bad++; $display("FAIL illegal_dec%0d got st=%0d ill/rw/mw=%b want st=%0d 100", k, State, {Illegal, RegWrite, MemWrite}, S_DECODE);
         end
         tick();
         n_cmp++;
         if ({State, Illegal, RegWrite, MemWrite} !== {4'(S_FETCH), 3'b000}) begin
            n_bad++; $display("FAIL illegal_next%0d got st=%0d ill/rw/mw=%b want st=%0d 000", k, State, {Illegal, RegWrite, MemWrite}, S_FETCH);
         end
      end
      Funct = 6'd0;
   endtask

   task automatic test_sw_reset;
      Op = OP_SW;
      tick();
      tick();
      tick();
      n_cmp++;
      if ({State, MemWrite, IorD} !== {4'(S_MEMWR), 2'b11}) begin
         n_bad++; $display("FAIL sw_memwr got st=%0d mw/iord=%b want st=%0d 11", State, {MemWrite, IorD}, S_MEMWR);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({State, MemWrite, RegWrite} !== {4'(S_IDLE), 2'b00}) begin
         n_bad++; $display("FAIL sw_async_reset got st=%0d mw/rw=%b want st=%0d 00", State, {MemWrite, RegWrite}, S_IDLE);
      end
      tick();
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if ({State, IRWrite} !== {4'(S_FETCH), 1'b1}) begin
         n_bad++; $display("FAIL sw_resume got st=%0d irw=%b want st=%0d 1", State, IRWrite, S_FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_branch();
      test_addi_jump();
      test_illegal();
      test_sw_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
